// File: rtl/leaf_spine_uplink.sv
`default_nettype none
// ============================================================================
// Module   : leaf_spine_uplink
// Brief    : Leaf end of a leaf-to-spine link. It has a TX FIFO with a stall-aware
//            send FSM, and an RX address filter feeding a FWFT FIFO.
//            The optional flit parity feature is enabled by LEAF_UPLINK_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_spine_uplink #(
    parameter logic [3:0] GROUP_ID   = 4'b0001,
    parameter int         LEAF_ID    = 0,
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] local_tx_data,
    input  logic              local_tx_valid,
    output logic              local_tx_ready,
    output logic [DWIDTH-1:0] spine_in_data,
    output logic              spine_in_valid,
    input  logic              spine_full,
    input  logic [DWIDTH-1:0] spine_out_data,
    input  logic              spine_out_valid,
    output logic [DWIDTH-1:0] local_rx_data,
    output logic              local_rx_valid,
    input  logic              local_rx_ready,
`ifdef LEAF_UPLINK_PARITY_EN
    output logic [7:0]        drop_parity_cnt,
`endif
    output logic [7:0]        drop_misroute_cnt,
    output logic [7:0]        drop_overflow_cnt
);

    localparam int             c_AW     = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_DEPTH  = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_CNT1   = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR1  = (c_AW)'(1);
    localparam logic [1:0]     c_LEAF   = LEAF_ID[1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } tx_state_e;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]   tx_wr_q;
    logic [c_AW-1:0]   tx_rd_q;
    logic [c_AW:0]     tx_cnt_q;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic [DWIDTH-1:0] w_tx_head;
    logic [DWIDTH-1:0] w_tx_out;

    tx_state_e         tx_state_q;
    tx_state_e         tx_state_d;
    logic [DWIDTH-1:0] spine_in_data_q;
    logic              spine_in_valid_q;

    assign w_tx_full      = (tx_cnt_q == c_DEPTH);
    assign w_tx_empty     = (tx_cnt_q == '0);
    assign w_tx_push      = local_tx_valid && !w_tx_full;
    assign local_tx_ready = !w_tx_full;
    assign w_tx_head      = tx_mem_q[tx_rd_q];

`ifdef LEAF_UPLINK_PARITY_EN
    assign w_tx_out = {w_tx_head[DWIDTH-1:1], ^w_tx_head[DWIDTH-1:1]};
`else
    assign w_tx_out = w_tx_head;
`endif

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            tx_mem_q[tx_wr_q] <= local_tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (w_tx_push) begin
                tx_wr_q <= tx_wr_q + c_PTR1;
            end
            if (w_tx_pop) begin
                tx_rd_q <= tx_rd_q + c_PTR1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + c_CNT1;
                2'b01:   tx_cnt_q <= tx_cnt_q - c_CNT1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX send FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        w_tx_pop   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!w_tx_empty) begin
                    tx_state_d = spine_full ? ST_STALL : ST_SEND;
                end
            end
            ST_SEND: begin
                if (spine_full) begin
                    tx_state_d = ST_STALL;
                end else if (!w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    // Last entry leaving with nothing arriving behind it.
                    if ((tx_cnt_q == c_CNT1) && !w_tx_push) begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!spine_full) begin
                    tx_state_d = w_tx_empty ? ST_IDLE : ST_SEND;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spine_in_data_q  <= '0;
            spine_in_valid_q <= 1'b0;
        end else begin
            spine_in_valid_q <= w_tx_pop;
            if (w_tx_pop) begin
                spine_in_data_q <= w_tx_out;
            end
        end
    end

    assign spine_in_data  = spine_in_data_q;
    assign spine_in_valid = spine_in_valid_q;

    // ------------------------------------------------------------------
    // RX filter and FIFO
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]   rx_wr_q;
    logic [c_AW-1:0]   rx_rd_q;
    logic [c_AW:0]     rx_cnt_q;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_rx_dest_ok;
    logic              w_rx_par_err;
    logic              w_rx_accept;
    logic              w_rx_misroute;
    logic              w_rx_overflow;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic [7:0]        misroute_cnt_q;
    logic [7:0]        overflow_cnt_q;

    assign w_rx_full    = (rx_cnt_q == c_DEPTH);
    assign w_rx_empty   = (rx_cnt_q == '0);
    assign w_rx_dest_ok = (spine_out_data[DWIDTH-1 -: 4] == GROUP_ID) &&
                          (spine_out_data[DWIDTH-5 -: 2] == c_LEAF);

`ifdef LEAF_UPLINK_PARITY_EN
    assign w_rx_par_err = spine_out_valid && (^spine_out_data);
`else
    assign w_rx_par_err = 1'b0;
`endif

    // Parity errors take precedence over the address check.
    assign w_rx_accept   = spine_out_valid && !w_rx_par_err && w_rx_dest_ok;
    assign w_rx_misroute = spine_out_valid && !w_rx_par_err && !w_rx_dest_ok;
    assign w_rx_push     = w_rx_accept && !w_rx_full;
    assign w_rx_overflow = w_rx_accept && w_rx_full;
    assign w_rx_pop      = !w_rx_empty && local_rx_ready;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            rx_mem_q[rx_wr_q] <= spine_out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (w_rx_push) begin
                rx_wr_q <= rx_wr_q + c_PTR1;
            end
            if (w_rx_pop) begin
                rx_rd_q <= rx_rd_q + c_PTR1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + c_CNT1;
                2'b01:   rx_cnt_q <= rx_cnt_q - c_CNT1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misroute_cnt_q <= '0;
            overflow_cnt_q <= '0;
        end else begin
            if (w_rx_misroute && (misroute_cnt_q != 8'hFF)) begin
                misroute_cnt_q <= misroute_cnt_q + 8'd1;
            end
            if (w_rx_overflow && (overflow_cnt_q != 8'hFF)) begin
                overflow_cnt_q <= overflow_cnt_q + 8'd1;
            end
        end
    end

`ifdef LEAF_UPLINK_PARITY_EN
    logic [7:0] parity_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_cnt_q <= '0;
        end else if (w_rx_par_err && (parity_cnt_q != 8'hFF)) begin
            parity_cnt_q <= parity_cnt_q + 8'd1;
        end
    end

    assign drop_parity_cnt = parity_cnt_q;
`endif

    // Head is masked while empty so stale RAM contents never reach the port.
    assign local_rx_data     = w_rx_empty ? '0 : rx_mem_q[rx_rd_q];
    assign local_rx_valid    = !w_rx_empty;
    assign drop_misroute_cnt = misroute_cnt_q;
    assign drop_overflow_cnt = overflow_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_spine_uplink.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_spine_uplink
// Brief    : Directed scoreboard bench for leaf_spine_uplink (GROUP 1, LEAF 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_spine_uplink;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] local_tx_data;
    logic        local_tx_valid;
    logic        local_tx_ready;
    logic [15:0] spine_in_data;
    logic        spine_in_valid;
    logic        spine_full;
    logic [15:0] spine_out_data;
    logic        spine_out_valid;
    logic [15:0] local_rx_data;
    logic        local_rx_valid;
    logic        local_rx_ready;
    logic [7:0]  drop_misroute_cnt;
    logic [7:0]  drop_overflow_cnt;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int rx_seen = 0;
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];

    leaf_spine_uplink #(
        .GROUP_ID   (4'b0001),
        .LEAF_ID    (2),
        .DWIDTH     (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .local_tx_data     (local_tx_data),
        .local_tx_valid    (local_tx_valid),
        .local_tx_ready    (local_tx_ready),
        .spine_in_data     (spine_in_data),
        .spine_in_valid    (spine_in_valid),
        .spine_full        (spine_full),
        .spine_out_data    (spine_out_data),
        .spine_out_valid   (spine_out_valid),
        .local_rx_data     (local_rx_data),
        .local_rx_valid    (local_rx_valid),
        .local_rx_ready    (local_rx_ready),
        .drop_misroute_cnt (drop_misroute_cnt),
        .drop_overflow_cnt (drop_overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs change only on posedge; negedge sampling is race-free.
    always @(negedge clk) begin
        if (spine_in_valid === 1'b1) begin
            check("tx_flit_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) begin
                check("tx_flit_data", 32'(spine_in_data), 32'(tx_q.pop_front()));
            end
            tx_seen++;
        end
        if (local_rx_valid === 1'b1 && local_rx_ready === 1'b1) begin
            check("rx_flit_expected", 32'(rx_q.size() != 0), 32'd1);
            if (rx_q.size() != 0) begin
                check("rx_flit_data", 32'(local_rx_data), 32'(rx_q.pop_front()));
            end
            rx_seen++;
        end
    end

    initial begin
        int tx_base;
        int rx_base;

        reset           = 1'b1;
        local_tx_data   = '0;
        local_tx_valid  = 1'b0;
        spine_full      = 1'b0;
        spine_out_data  = '0;
        spine_out_valid = 1'b0;
        local_rx_ready  = 1'b1;
        tick();
        tick();
        check("rst_spine_in_valid", 32'(spine_in_valid), 32'd0);
        check("rst_spine_in_data", 32'(spine_in_data), 32'd0);
        check("rst_rx_valid", 32'(local_rx_valid), 32'd0);
        check("rst_rx_data", 32'(local_rx_data), 32'd0);
        check("rst_tx_ready", 32'(local_tx_ready), 32'd1);
        check("rst_misroute", 32'(drop_misroute_cnt), 32'd0);
        check("rst_overflow", 32'(drop_overflow_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // 1: three back-to-back flits, first valid two edges after first push
        local_tx_valid = 1'b1;
        local_tx_data  = 16'h1001; tx_q.push_back(16'h1001);
        tick();
        check("t1_valid_e0", 32'(spine_in_valid), 32'd0);
        check("t1_ready_e0", 32'(local_tx_ready), 32'd1);
        local_tx_data  = 16'h1002; tx_q.push_back(16'h1002);
        tick();
        check("t1_valid_e1", 32'(spine_in_valid), 32'd0);
        local_tx_data  = 16'h1003; tx_q.push_back(16'h1003);
        tick();
        local_tx_valid = 1'b0;
        check("t1_valid_e2", 32'(spine_in_valid), 32'd1);
        check("t1_ready_e2", 32'(local_tx_ready), 32'd1);
        tick();
        check("t1_valid_e3", 32'(spine_in_valid), 32'd1);
        tick();
        check("t1_valid_e4", 32'(spine_in_valid), 32'd1);
        tick();
        check("t1_valid_e5", 32'(spine_in_valid), 32'd0);
        check("t1_all_sent", 32'(tx_q.size()), 32'd0);

        // 2: fill against a stalled spine, ninth push rejected
        spine_full = 1'b1;
        tx_base = tx_seen;
        for (int i = 0; i < 8; i++) begin
            local_tx_valid = 1'b1;
            local_tx_data  = 16'h2000 + 16'(i);
            tx_q.push_back(16'h2000 + 16'(i));
            tick();
        end
        check("t2_ready_full", 32'(local_tx_ready), 32'd0);
        local_tx_data = 16'h2FFF;
        tick();
        local_tx_valid = 1'b0;
        check("t2_ready_still_full", 32'(local_tx_ready), 32'd0);
        check("t2_valid_stalled", 32'(spine_in_valid), 32'd0);
        spine_full = 1'b0;
        for (int k = 0; k < 40 && tx_q.size() != 0; k++) tick();
        tick();
        tick();
        check("t2_drained", 32'(tx_q.size()), 32'd0);
        check("t2_count", 32'(tx_seen - tx_base), 32'd8);
        check("t2_idle_valid", 32'(spine_in_valid), 32'd0);
        check("t2_idle_ready", 32'(local_tx_ready), 32'd1);

        // 3: spine_full pulses while streaming six flits
        tx_base = tx_seen;
        for (int i = 0; i < 36; i++) begin
            spine_full     = (i % 3 == 0);
            local_tx_valid = (i < 6);
            local_tx_data  = 16'h3100 + 16'(i);
            if (i < 6) tx_q.push_back(16'h3100 + 16'(i));
            tick();
            if (i % 3 == 0) check("t3_valid_after_full", 32'(spine_in_valid), 32'd0);
        end
        spine_full     = 1'b0;
        local_tx_valid = 1'b0;
        for (int k = 0; k < 40 && tx_q.size() != 0; k++) tick();
        tick();
        check("t3_drained", 32'(tx_q.size()), 32'd0);
        check("t3_count", 32'(tx_seen - tx_base), 32'd6);

        // 4: one matching flit, one wrong-group flit
        rx_base = rx_seen;
        spine_out_valid = 1'b1;
        spine_out_data  = 16'h1800; rx_q.push_back(16'h1800);
        tick();
        check("t4_rx_valid", 32'(local_rx_valid), 32'd1);
        check("t4_rx_data", 32'(local_rx_data), 32'h1800);
        spine_out_data  = 16'h2800;
        tick();
        spine_out_valid = 1'b0;
        tick();
        check("t4_misroute", 32'(drop_misroute_cnt), 32'd1);
        check("t4_overflow", 32'(drop_overflow_cnt), 32'd0);
        check("t4_rx_count", 32'(rx_seen - rx_base), 32'd1);

        // 5: overflow the RX FIFO with the consumer stalled
        local_rx_ready = 1'b0;
        rx_base = rx_seen;
        for (int i = 1; i <= 9; i++) begin
            spine_out_valid = 1'b1;
            spine_out_data  = 16'h1800 | 16'(i);
            if (i <= 8) rx_q.push_back(16'h1800 | 16'(i));
            tick();
        end
        spine_out_valid = 1'b0;
        check("t5_overflow", 32'(drop_overflow_cnt), 32'd1);
        check("t5_rx_valid", 32'(local_rx_valid), 32'd1);
        local_rx_ready = 1'b1;
        for (int k = 0; k < 40 && rx_q.size() != 0; k++) tick();
        tick();
        check("t5_drained", 32'(rx_q.size()), 32'd0);
        check("t5_count", 32'(rx_seen - rx_base), 32'd8);
        check("t5_rx_empty", 32'(local_rx_valid), 32'd0);

        // Misroute counter saturation
        spine_out_valid = 1'b1;
        spine_out_data  = 16'h2800;
        for (int i = 0; i < 300; i++) tick();
        spine_out_valid = 1'b0;
        tick();
        check("sat_misroute", 32'(drop_misroute_cnt), 32'd255);
        check("sat_overflow_kept", 32'(drop_overflow_cnt), 32'd1);

        // 6: reset with flits buffered on both paths
        spine_full     = 1'b1;
        local_rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            local_tx_valid = 1'b1;
            local_tx_data  = 16'h6000 + 16'(i);
            spine_out_valid = (i < 3);
            spine_out_data  = 16'h1840 + 16'(i);
            tick();
        end
        local_tx_valid  = 1'b0;
        spine_out_valid = 1'b0;
        check("t6_rx_buffered", 32'(local_rx_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_spine_valid", 32'(spine_in_valid), 32'd0);
        check("t6_rx_valid", 32'(local_rx_valid), 32'd0);
        check("t6_rx_data", 32'(local_rx_data), 32'd0);
        check("t6_tx_ready", 32'(local_tx_ready), 32'd1);
        check("t6_misroute", 32'(drop_misroute_cnt), 32'd0);
        check("t6_overflow", 32'(drop_overflow_cnt), 32'd0);
        tx_base = tx_seen;
        rx_base = rx_seen;
        spine_full     = 1'b0;
        local_rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("t6_no_stale_tx", 32'(tx_seen - tx_base), 32'd0);
        check("t6_no_stale_rx", 32'(rx_seen - rx_base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
